// File: rtl/modinv_for_1481_pkg.sv
// Shared constants, state encoding and reduction helper for the GF(1481) inverter.
package modinv_for_1481_pkg;

  localparam int W = 11;
  localparam int RW = 2 * W + 2;  // headroom width for the Barrett remainder

  localparam logic [W-1:0] Q   = 11'd1481;
  localparam logic [W:0]   MU  = 12'd2832;  // floor(2^22 / 1481)
  localparam logic [W-1:0] EXP = 11'd1479;  // Q-2, scanned MSB-first

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQR  = 3'd1,
    MUL  = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4
  } state_t;

  // One conditional subtraction of Q on the wide remainder.
  function automatic logic [RW-1:0] cond_sub_q(input logic [RW-1:0] v);
    logic [RW-1:0] q_w;
    q_w = {{(RW - W){1'b0}}, Q};
    return (v >= q_w) ? (v - q_w) : v;
  endfunction

endpackage

// File: rtl/barret_mulred_1481.sv
// Combinational a*b mod 1481 using Barrett reduction with two correction steps.
module barret_mulred_1481
  import modinv_for_1481_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  logic [2*W-1:0] x;      // full product, up to 1480^2
  logic [2*W:0]   th;     // (x >> W) * MU
  logic [W:0]     t;      // quotient estimate, never above floor(x/Q)
  logic [RW-1:0]  tq;
  logic [RW-1:0]  r0;     // in [0, 3Q)
  logic [RW-1:0]  r1;
  logic [RW-1:0]  r2;
  logic           unused_bits;

  // Quotient estimate, remainder and the two corrections that bring it into [0,Q-1].
  always_comb begin
    x  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    th = {{(W + 1){1'b0}}, x[2*W-1:W]} * {{W{1'b0}}, MU};
    t  = th[2*W:W];
    tq = {{(RW - W - 1){1'b0}}, t} * {{(RW - W){1'b0}}, Q};
    r0 = {2'b00, x} - tq;
    r1 = cond_sub_q(r0);
    r2 = cond_sub_q(r1);
    p  = r2[W-1:0];
  end

  assign unused_bits = ^{th[W-1:0], r2[RW-1:W]};

endmodule

// File: rtl/modinv_for_1481.sv
// Constant-time modular inverter over GF(1481): dout_r = din_a^(Q-2) mod Q.
// Square-and-multiply, one shared modular multiplier, fixed latency of 2W cycles.
// Optional build macro MODINV_CHECK_EN adds a CHK state that verifies base*acc == 1
// (latency 2W+1) and flags a failed check through dout_err.
module modinv_for_1481
  import modinv_for_1481_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout_r,
  output logic         dout_err
);

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   base_q;
  logic [3:0]     idx_q;
  logic           err_q;
  logic [W-1:0]   din_red;
  logic [W-1:0]   mr_b;
  logic [W-1:0]   mr_p;

  // A raw 11-bit operand is below 2Q, so one subtraction reduces it.
  assign din_red = (din_a >= Q) ? (din_a - Q) : din_a;

  // SQR squares acc; MUL and CHK multiply acc by base.
  assign mr_b = (state_q == SQR) ? acc_q : base_q;

  barret_mulred_1481 u_mulred (
    .a (acc_q),
    .b (mr_b),
    .p (mr_p)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout_r    = (state_q == DONE && !err_q) ? acc_q : '0;
  assign dout_err  = (state_q == DONE) && err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: exponent scan, then hold the result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = SQR;
      SQR:  state_d = MUL;
      MUL: begin
        if (idx_q != 4'd0) state_d = SQR;
`ifdef MODINV_CHECK_EN
        else               state_d = CHK;
`else
        else               state_d = DONE;
`endif
      end
`ifdef MODINV_CHECK_EN
      CHK:  state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, accumulator updates and bit index countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      base_q <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            base_q <= din_red;
            acc_q  <= {{(W - 1){1'b0}}, 1'b1};
            idx_q  <= 4'(W - 1);
            err_q  <= (din_red == '0);
          end
        end
        SQR: acc_q <= mr_p;
        MUL: begin
          // Product is always formed; it is simply not kept for a zero bit.
          if (EXP[idx_q]) acc_q <= mr_p;
          if (idx_q != 4'd0) idx_q <= idx_q - 4'd1;
        end
`ifdef MODINV_CHECK_EN
        CHK: begin
          if (mr_p != {{(W - 1){1'b0}}, 1'b1} && !err_q) err_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
